// File: rtl/mips32i_data_ram.sv
// rtl/mips32i_data_ram.sv - Byte-lane data RAM with a fixed-latency one-at-a-time request/response handshake.
// Optional macro DMEM_MISALIGN_TRAP_EN: flag misaligned halfword/word accesses instead of silently aligning them.
module mips32i_data_ram #(
    parameter int DEPTH_WORDS = 16384,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  size_sel,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        resp_valid,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [1:0]    size_q, size_d;
    logic          sext_q, sext_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          mis_q, mis_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          in_idle;
    logic          e_wr;
    logic [1:0]    e_size;
    logic          e_sext;
    logic [AW+1:0] e_addr;
    logic [31:0]   e_wdata;
    logic [AW-1:0] widx;
    logic [1:0]    off;
    logic          e_mis;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [31:0]   rword;
    logic [31:0]   load_data;
    logic          enter_resp;
    logic          mem_we;

    logic          unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];

    // With zero wait states the access happens on the accept edge, so use the live inputs in IDLE.
    assign in_idle = (state_q == S_IDLE);
    assign e_wr    = in_idle ? req_wr            : wr_q;
    assign e_size  = in_idle ? size_sel          : size_q;
    assign e_sext  = in_idle ? sign_ext          : sext_q;
    assign e_addr  = in_idle ? addr[AW+1:0]      : addr_q;
    assign e_wdata = in_idle ? wdata             : wdata_q;
    assign widx    = e_addr[AW+1:2];

    always_comb begin
        off   = 2'b00;
        e_mis = 1'b0;
        be    = 4'b0000;
        wlane = e_wdata;
        case (e_size)
            2'b00: begin
                off   = e_addr[1:0];
                be    = 4'b0001 << off;
                wlane = {4{e_wdata[7:0]}};
            end
            2'b01: begin
                off   = {e_addr[1], 1'b0};
                be    = 4'b0011 << off;
                wlane = {2{e_wdata[15:0]}};
            end
            2'b11: be = 4'b1111;
            default: be = 4'b0000;
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        e_mis = ((e_size == 2'b01) && e_addr[0]) || ((e_size == 2'b11) && (e_addr[1:0] != 2'b00));
`else
        e_mis = 1'b0;
`endif
        if (e_mis) begin
            be = 4'b0000;
        end
    end

    always_comb begin
        rword     = mem[widx] >> {off, 3'b000};
        load_data = 32'h0;
        case (e_size)
            2'b00:   load_data = {{24{e_sext & rword[7]}}, rword[7:0]};
            2'b01:   load_data = {{16{e_sext & rword[15]}}, rword[15:0]};
            2'b11:   load_data = rword;
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        size_d     = size_q;
        sext_d     = sext_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = 32'h0;
        mis_d      = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    size_d  = size_sel;
                    sext_d  = sign_ext;
                    addr_d  = addr[AW+1:0];
                    wdata_d = wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d    = S_RESP;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (enter_resp && !e_wr && !e_mis) begin
            rdata_d = load_data;
        end
        mis_d = enter_resp & e_mis;
    end

    // Gating with rst keeps a reset that lands mid-transaction from committing the store.
    assign mem_we = enter_resp & e_wr & rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign resp_valid   = (state_q == S_RESP);
    assign rdata        = rdata_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_mips32i_data_ram.sv
// tb/tb_mips32i_data_ram.sv - Scoreboard bench for mips32i_data_ram with one-wait and zero-wait instances.
module tb_mips32i_data_ram;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rv1 = 1'b0, rv0 = 1'b0;
    logic        req_wr = 1'b0;
    logic [1:0]  size_sel = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        rdy1, rdy0, resp1, resp0, mis1, mis0;
    logic [31:0] rdata1, rdata0;

    logic [31:0] pend_rd = 32'h0;
    logic        pend_mis = 1'b0;
    exp_t        q1[$], q0[$];
    int          cyc = 0;
    int          n_chk = 0, n_err = 0;

    mips32i_data_ram #(.DEPTH_WORDS(16384), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1), .req_wr(req_wr),
        .size_sel(size_sel), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .resp_valid(resp1), .misalign_err(mis1));

    mips32i_data_ram #(.DEPTH_WORDS(16384), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0), .req_wr(req_wr),
        .size_sel(size_sel), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .resp_valid(resp0), .misalign_err(mis0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rv1 && rdy1) q1.push_back('{pend_rd, pend_mis, cyc});
        if (resp1) begin
            check("d1_ready_in_resp", 32'(rdy1), 32'd0);
            if (q1.size() == 0) begin
                check("d1_spurious_resp", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("d1_rdata", rdata1, e.rd);
                check("d1_misalign", 32'(mis1), 32'(e.mis));
                check("d1_latency", 32'(cyc - e.acc), 32'd2);
            end
        end else begin
            check("d1_idle_rdata", rdata1, 32'h0);
            check("d1_idle_mis", 32'(mis1), 32'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rv0 && rdy0) q0.push_back('{pend_rd, pend_mis, cyc});
        if (resp0) begin
            check("d0_ready_in_resp", 32'(rdy0), 32'd0);
            if (q0.size() == 0) begin
                check("d0_spurious_resp", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                check("d0_rdata", rdata0, e.rd);
                check("d0_misalign", 32'(mis0), 32'(e.mis));
                check("d0_latency", 32'(cyc - e.acc), 32'd1);
            end
        end else begin
            check("d0_idle_rdata", rdata0, 32'h0);
            check("d0_idle_mis", 32'(mis0), 32'd0);
        end
    end

    task automatic do_req(input bit sel, input logic wr, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_mis);
        int n;
        @(posedge clk); #1;
        req_wr = wr; size_sel = sz; sign_ext = sx; addr = a; wdata = wd;
        pend_rd = exp_rd; pend_mis = exp_mis;
        if (sel) rv0 = 1'b1; else rv1 = 1'b1;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(sel ? rdy0 : rdy1) && n < 20);
        if (n >= 20) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        rv0 = 1'b0; rv1 = 1'b0;
        n = 0;
        while ((sel ? q0.size() : q1.size()) != 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("resp_timeout", 32'(sel ? q0.size() : q1.size()), 32'd0);
    endtask

    initial begin
        int nacc;
        #12;
        check("rst_ready", 32'(rdy1), 32'd1);
        check("rst_resp", 32'(resp1), 32'd0);
        check("rst_rdata", rdata1, 32'h0);
        check("rst_mis", 32'(mis1), 32'd0);
        check("rst_ready0", 32'(rdy0), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;

        do_req(0, 1, 2'b11, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        do_req(0, 0, 2'b11, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        do_req(0, 1, 2'b00, 0, 32'h13, 32'h80, 32'h0, 0);
        do_req(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFFFF80, 0);
        do_req(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'h00000080, 0);
        do_req(0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0);
        do_req(0, 0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFF80AD, 0);
        do_req(0, 0, 2'b01, 0, 32'h12, 32'h0, 32'h000080AD, 0);
        do_req(0, 1, 2'b10, 0, 32'h10, 32'hFFFFFFFF, 32'h0, 0);
        do_req(0, 0, 2'b10, 1, 32'h10, 32'h0, 32'h0, 0);
        do_req(0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        do_req(0, 1, 2'b01, 0, 32'h21, 32'h1234, 32'h0, 1);
        do_req(0, 0, 2'b11, 0, 32'h20, 32'h0, 32'h00000000, 0);
`else
        do_req(0, 1, 2'b01, 0, 32'h21, 32'h1234, 32'h0, 0);
        do_req(0, 0, 2'b11, 0, 32'h20, 32'h0, 32'h00001234, 0);
`endif
        do_req(0, 1, 2'b11, 0, 32'h10000, 32'h11111111, 32'h0, 0);
        do_req(0, 0, 2'b11, 0, 32'h0, 32'h0, 32'h11111111, 0);

        do_req(0, 1, 2'b11, 0, 32'h40, 32'h0, 32'h0, 0);
        @(posedge clk); #1;
        req_wr = 1'b1; size_sel = 2'b11; addr = 32'h40; wdata = 32'hCAFEF00D;
        pend_rd = 32'h0; pend_mis = 1'b0; rv1 = 1'b1;
        @(posedge clk); #1;
        rv1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", 32'(rdy1), 32'd1);
        check("abort_resp", 32'(resp1), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("abort_no_resp", 32'(q1.size()), 32'd1);
        q1.delete();
        do_req(0, 0, 2'b11, 0, 32'h40, 32'h0, 32'h00000000, 0);

        do_req(1, 1, 2'b11, 0, 32'h8, 32'h5A5A5A5A, 32'h0, 0);
        @(posedge clk); #1;
        req_wr = 1'b0; size_sel = 2'b11; sign_ext = 1'b0; addr = 32'h8;
        pend_rd = 32'h5A5A5A5A; pend_mis = 1'b0; rv0 = 1'b1;
        nacc = 0;
        repeat (8) begin
            @(negedge clk); #1;
            if (rv0 && rdy0) nacc++;
        end
        @(posedge clk); #1;
        rv0 = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("burst_accepts", 32'(nacc), 32'd4);
        check("burst_drained", 32'(q0.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
